// File: rtl/multi_db_pkg.sv
// rtl/multi_db_pkg.sv - shared types and helpers for the multi-channel debounce controller
package multi_db_pkg;

    typedef enum logic [1:0] {
        CH_ZERO  = 2'd0,
        CH_WAIT1 = 2'd1,
        CH_ONE   = 2'd2,
        CH_WAIT0 = 2'd3
    } ch_state_t;

    // Sized for the largest supported channel count; the top truncates to its own width.
    localparam int MAX_CHAN_W = 4;

    typedef struct packed {
        logic [MAX_CHAN_W-1:0] chan;
        logic                  rise;
    } event_t;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/db_event_fifo.sv
// rtl/db_event_fifo.sv - show-ahead event FIFO with registered occupancy count
module db_event_fifo
    import multi_db_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  event_t push_data,
    input  logic   pop,
    output event_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    event_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/multi_db_event_ctrl.sv
// rtl/multi_db_event_ctrl.sv - N-channel early debouncer with round-robin event FIFO
// Optional DB_SYNC_EN adds a 2-FF input synchronizer in front of the channel FSMs.
module multi_db_event_ctrl
    import multi_db_pkg::*;
#(
    parameter int N          = 4,
    parameter int TICK_M     = 1_000_000,
    parameter int WAIT_TICKS = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         sw,
    output logic [N-1:0]         db,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [chan_w(N)-1:0] ev_chan,
    output logic                 ev_rise,
    output logic                 overflow,
    input  logic                 clr_ovf
);

    localparam int CW = chan_w(N);
    localparam int TW = (TICK_M > 1) ? $clog2(TICK_M) : 1;
    localparam logic [1:0] WLAST = 2'(WAIT_TICKS - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_M - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    logic [N-1:0] sw_s;

`ifdef DB_SYNC_EN
    logic [N-1:0] sw_meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= sw;
            sw_s    <= sw_meta;
        end
    end
`else
    assign sw_s = sw;
`endif

    ch_state_t    state    [N];
    ch_state_t    state_nx [N];
    logic [1:0]   wcnt     [N];
    logic [1:0]   wcnt_nx  [N];
    logic [N-1:0] ev_set;
    logic [N-1:0] ev_type;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                state[i] <= CH_ZERO;
                wcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                state[i] <= state_nx[i];
                wcnt[i]  <= wcnt_nx[i];
            end
        end
    end

    // Edges are taken immediately; the input is then ignored until WAIT_TICKS ticks pass.
    always_comb begin
        ev_set  = '0;
        ev_type = '0;
        db      = '0;
        for (int i = 0; i < N; i++) begin
            state_nx[i] = state[i];
            wcnt_nx[i]  = wcnt[i];
            db[i]       = (state[i] == CH_WAIT1) || (state[i] == CH_ONE);
            case (state[i])
                CH_ZERO: begin
                    if (sw_s[i]) begin
                        state_nx[i] = CH_WAIT1;
                        wcnt_nx[i]  = '0;
                        ev_set[i]   = 1'b1;
                        ev_type[i]  = 1'b1;
                    end
                end
                CH_WAIT1: begin
                    if (tick) begin
                        if (wcnt[i] == WLAST) state_nx[i] = CH_ONE;
                        else                  wcnt_nx[i]  = wcnt[i] + 1'b1;
                    end
                end
                CH_ONE: begin
                    if (!sw_s[i]) begin
                        state_nx[i] = CH_WAIT0;
                        wcnt_nx[i]  = '0;
                        ev_set[i]   = 1'b1;
                    end
                end
                CH_WAIT0: begin
                    if (tick) begin
                        if (wcnt[i] == WLAST) state_nx[i] = CH_ZERO;
                        else                  wcnt_nx[i]  = wcnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_nx[i] = CH_ZERO;
                    wcnt_nx[i]  = '0;
                end
            endcase
        end
    end

    logic [N-1:0]  pend;
    logic [N-1:0]  ptype;
    logic [CW-1:0] rr_ptr;
    logic [CW-1:0] gnt_idx;
    logic [N-1:0]  gnt_oh;
    logic [N-1:0]  lost;
    logic          gnt;
    logic          fifo_full;
    logic          fifo_empty;
    event_t        push_ev;
    event_t        head;
    int            idx;

    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!gnt && pend[idx] && !fifo_full) begin
                gnt         = 1'b1;
                gnt_idx     = CW'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    // A pending event granted this cycle is not lost when a new one lands on top of it.
    assign lost = ev_set & pend & ~gnt_oh;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend     <= '0;
            ptype    <= '0;
            rr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ev_set[i]) begin
                    pend[i]  <= 1'b1;
                    ptype[i] <= ev_type[i];
                end else if (gnt_oh[i]) begin
                    pend[i]  <= 1'b0;
                end
            end
            if (gnt) rr_ptr <= (gnt_idx == CW'(N - 1)) ? '0 : gnt_idx + 1'b1;
            if (|lost)        overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign push_ev.chan = MAX_CHAN_W'(gnt_idx);
    assign push_ev.rise = ptype[gnt_idx];

    db_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (gnt),
        .push_data (push_ev),
        .pop       (ev_valid && ev_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_chan  = CW'(head.chan);
    assign ev_rise  = head.rise;

endmodule
